// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI command decoder / register bank:
// FSM encoding, command word layout and the reserved-field mask helper.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  localparam int          CMD_WR_BIT  = 15;
  localparam logic [15:0] ID_WORD_DEF = 16'h5A01;

  // Bits 14 down to addr_w of a command word must be zero.
  function automatic logic [15:0] rsvd_mask(input int unsigned addr_w);
    logic [15:0] low;
    low = (16'd1 << addr_w) - 16'd1;
    return 16'h7FFF & ~low;
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Command decoder and auto-incrementing register bank behind a 16-bit SPI
// slave word interface: first word of a frame is the command, the rest is data.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int          NREGS   = 8,
  parameter int          ADDR_W  = 3,
  parameter logic [15:0] ID_WORD = ID_WORD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ssel,
  input  logic                  word_valid,
  input  logic [15:0]           word_in,
  input  logic                  data_needed,
  output logic [15:0]           tx_word,
  output logic [16*NREGS-1:0]   regs_q,
  output logic                  wr_pulse,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  cmd_err
);

  localparam logic [15:0] RSVD = rsvd_mask(ADDR_W);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_inc;
  logic                vld_p0;
  logic [15:0]         regs [NREGS];

  logic                cmd_bad;
  logic                cmd_wr;
  logic [ADDR_W-1:0]   cmd_addr;

  // Underrun reporting is not exposed on this block, so the hint is parked here.
  logic                unused_ok;
  assign unused_ok = data_needed;

  assign ptr_inc  = ptr + ADDR_W'(1);
  assign cmd_bad  = |(word_in & RSVD);
  assign cmd_wr   = word_in[CMD_WR_BIT];
  assign cmd_addr = word_in[ADDR_W-1:0];

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign regs_q[16*i +: 16] = regs[i];
  end

  // Stage p0: word_valid marks the next cycle as the capture cycle; the
  // capture itself (word_in sampled) happens at the end of that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      vld_p0   <= 1'b0;
      tx_word  <= ID_WORD;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      cmd_err  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
    end else begin
      wr_pulse <= 1'b0;
      vld_p0   <= word_valid & ~ssel;
      if (ssel) begin
        state   <= ST_IDLE;
        ptr     <= '0;
        tx_word <= ID_WORD;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_CMD;
            tx_word <= ID_WORD;
          end
          ST_CMD: begin
            if (vld_p0) begin
              ptr <= cmd_addr;
              if (cmd_bad) begin
                state   <= ST_DISCARD;
                cmd_err <= 1'b1;
                tx_word <= 16'h0000;
              end else if (cmd_wr) begin
                state   <= ST_WRITE;
                tx_word <= 16'h0000;
              end else begin
                state   <= ST_READ;
                tx_word <= regs[cmd_addr];
              end
            end
          end
          ST_WRITE: begin
            if (vld_p0) begin
              regs[ptr] <= word_in;
              wr_pulse  <= 1'b1;
              wr_addr   <= ptr;
              ptr       <= ptr_inc;
            end
          end
          ST_READ: begin
            // Preload the word the master will clock out next.
            if (vld_p0) begin
              ptr     <= ptr_inc;
              tx_word <= regs[ptr_inc];
            end
          end
          ST_DISCARD: begin
            tx_word <= 16'h0000;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with a write scoreboard checked on wr_pulse.
module tb_spi_reg_bank;

  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                ssel;
  logic                word_valid;
  logic [15:0]         word_in;
  logic                data_needed;
  logic [15:0]         tx_word;
  logic [16*NREGS-1:0] regs_q;
  logic                wr_pulse;
  logic [ADDR_W-1:0]   wr_addr;
  logic                cmd_err;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  spi_reg_bank #(.NREGS(NREGS), .ADDR_W(ADDR_W), .ID_WORD(16'h5A01)) dut (
    .clk(clk), .rst_n(rst_n), .ssel(ssel), .word_valid(word_valid),
    .word_in(word_in), .data_needed(data_needed), .tx_word(tx_word),
    .regs_q(regs_q), .wr_pulse(wr_pulse), .wr_addr(wr_addr), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] reg_of(input int i);
    return regs_q[16*i +: 16];
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse word_valid, present the word in the capture cycle, return in C+1.
  task automatic send_word(input logic [15:0] w);
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    word_in    = w;
    tick();
  endtask

  task automatic gap();
    tick();
    tick();
  endtask

  task automatic frame_start();
    ssel = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_end();
    ssel = 1'b1;
    tick();
    tick();
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst_n && wr_pulse) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_unexpected: observed write addr %0d data %h expected none",
               wr_addr, reg_of(int'(wr_addr)));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checks++;
        assert (wr_addr === e.a) else begin
          errors++;
          $error("FAIL wr_addr: observed %0d expected %0d", wr_addr, e.a);
        end
        checks++;
        assert (reg_of(int'(e.a)) === e.d) else begin
          errors++;
          $error("FAIL wr_data: observed %h expected %h", reg_of(int'(e.a)), e.d);
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    ssel        = 1'b1;
    word_valid  = 1'b0;
    word_in     = 16'h0000;
    data_needed = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    check16("rst_tx", tx_word, 16'h5A01);
    check16("rst_wr_pulse", {15'd0, wr_pulse}, 16'h0000);
    tick();
    rst_n = 1'b1;
    gap();
    check16("idle_tx", tx_word, 16'h5A01);
    check16("idle_cmd_err", {15'd0, cmd_err}, 16'h0000);
    check16("idle_wr_addr", {13'd0, wr_addr}, 16'h0000);
    for (int i = 0; i < NREGS; i++) check16("idle_reg", reg_of(i), 16'h0000);

    // Write frame at address 2.
    frame_start();
    check16("cmd_tx_id", tx_word, 16'h5A01);
    push_wr(3'd2, 16'h1111);
    push_wr(3'd3, 16'h2222);
    send_word(16'h8002); gap();
    send_word(16'h1111); gap();
    send_word(16'h2222); gap();
    frame_end();
    check16("w_reg2", reg_of(2), 16'h1111);
    check16("w_reg3", reg_of(3), 16'h2222);

    // Write frame wrapping from 7 to 0.
    frame_start();
    push_wr(3'd7, 16'hAAAA);
    push_wr(3'd0, 16'hBBBB);
    send_word(16'h8007); gap();
    send_word(16'hAAAA); gap();
    send_word(16'hBBBB); gap();
    frame_end();
    check16("wrap_reg7", reg_of(7), 16'hAAAA);
    check16("wrap_reg0", reg_of(0), 16'hBBBB);

    // Read frame from address 2.
    frame_start();
    check16("rd_tx_id", tx_word, 16'h5A01);
    send_word(16'h0002);
    check16("rd_tx_w1", tx_word, 16'h1111);
    gap();
    check16("rd_tx_w1_hold", tx_word, 16'h1111);
    send_word(16'hFFFF);
    check16("rd_tx_w2", tx_word, 16'h2222);
    gap();
    send_word(16'h0000);
    check16("rd_tx_w3", tx_word, 16'h0000);
    frame_end();
    check16("rd_end_tx", tx_word, 16'h5A01);

    // Read wrapping from 7 to 0.
    frame_start();
    send_word(16'h0007);
    check16("rdw_tx_w1", tx_word, 16'hAAAA);
    gap();
    send_word(16'h1234);
    check16("rdw_tx_w2", tx_word, 16'hBBBB);
    frame_end();

    // Bad command: reserved bit set.
    frame_start();
    send_word(16'h0100);
    check16("bad_cmd_err", {15'd0, cmd_err}, 16'h0001);
    check16("bad_tx", tx_word, 16'h0000);
    gap();
    send_word(16'h9999); gap();
    send_word(16'h8888); gap();
    check16("bad_tx_hold", tx_word, 16'h0000);
    frame_end();

    // Next good frame, back-to-back word_valid pulses.
    frame_start();
    push_wr(3'd4, 16'h1234);
    push_wr(3'd5, 16'h5678);
    send_word(16'h8004); gap();
    word_valid = 1'b1;
    tick();
    word_in = 16'h1234;
    tick();
    word_valid = 1'b0;
    word_in    = 16'h5678;
    tick();
    gap();
    frame_end();
    check16("b2b_reg4", reg_of(4), 16'h1234);
    check16("b2b_reg5", reg_of(5), 16'h5678);
    check16("sticky_cmd_err", {15'd0, cmd_err}, 16'h0001);

    // Frame aborted between word_valid and capture.
    frame_start();
    send_word(16'h8001); gap();
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    ssel       = 1'b1;
    word_in    = 16'hDEAD;
    tick();
    check16("abort_wr_pulse", {15'd0, wr_pulse}, 16'h0000);
    check16("abort_tx", tx_word, 16'h5A01);
    tick();
    check16("abort_reg1", reg_of(1), 16'h0000);
    frame_start();
    push_wr(3'd6, 16'h7777);
    send_word(16'h8006); gap();
    send_word(16'h7777); gap();
    frame_end();
    check16("after_abort_reg6", reg_of(6), 16'h7777);
    check16("final_cmd_err", {15'd0, cmd_err}, 16'h0001);
    check16("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
